// File: rtl/prl_pkg.sv
// Shared USB-PD protocol-layer codes: SOP types, message classes, header type codes,
// the captured request record and the TX build FSM encoding.
package prl_pkg;

    localparam logic [2:0] SOP_SOP   = 3'd0;
    localparam logic [2:0] SOP_SOP_P = 3'd1;
    localparam logic [2:0] SOP_SOP_PP = 3'd2;

    localparam logic [1:0] MSG_TYPE_CONTROL  = 2'd0;
    localparam logic [1:0] MSG_TYPE_DATA     = 2'd1;
    localparam logic [1:0] MSG_TYPE_EXTENDED = 2'd2;
    localparam logic [1:0] MSG_TYPE_RESERVED = 2'd3;

    localparam logic [4:0] HT_SRC_CAP    = 5'h01;
    localparam logic [4:0] HT_STATUS     = 5'h02;
    localparam logic [4:0] HT_ALERT      = 5'h06;
    localparam logic [4:0] HT_PPS_STATUS = 5'h0C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } build_state_t;

    // Request fields frozen at build_start so the message cannot change mid-flight.
    typedef struct packed {
        logic [2:0]  msg_id;
        logic        power_role;
        logic        data_role;
        logic [2:0]  sop_type;
        logic [1:0]  message_type;
        logic [4:0]  header_type;
        logic [3:0]  table_select;
        logic [2:0]  pdo_num;
        logic [3:0]  alert_info;
        logic [8:0]  ex_data_size;
        logic        pps_omf;
        logic [1:0]  pps_ptp;
        logic [7:0]  pps_current;
        logic [15:0] pps_voltage;
        logic [1:0]  status_temp;
        logic [2:0]  status_event;
        logic [3:0]  status_present;
        logic [7:0]  status_internal_temp;
    } req_t;

endpackage

// File: rtl/prl_tx_payload_mux.sv
// Combinational payload byte selector: maps the captured request and the data byte
// index (0 = first byte after the header) to the byte on the wire.
module prl_tx_payload_mux
    import prl_pkg::*;
(
    input  logic [1:0]  message_type,
    input  logic [4:0]  header_type,
    input  logic [4:0]  byte_idx,
    input  logic [31:0] pdo_rd_data,
    input  logic [3:0]  alert_info,
    input  logic [8:0]  ex_data_size,
    input  logic        pps_omf,
    input  logic [1:0]  pps_ptp,
    input  logic [7:0]  pps_current,
    input  logic [15:0] pps_voltage,
    input  logic [1:0]  status_temp,
    input  logic [2:0]  status_event,
    input  logic [3:0]  status_present,
    input  logic [7:0]  status_internal_temp,
    output logic [7:0]  payload_byte
);

    logic [4:0] ext_idx;
    logic [7:0] ext_byte;
    logic [7:0] pdo_byte;

    // Extended data bytes are indexed after the 2-byte extended header.
    assign ext_idx = byte_idx - 5'd2;

    always_comb begin
        ext_byte = 8'h00;
        if (header_type == HT_PPS_STATUS) begin
            case (ext_idx)
                5'd0:    ext_byte = pps_voltage[7:0];
                5'd1:    ext_byte = pps_voltage[15:8];
                5'd2:    ext_byte = pps_current;
                5'd3:    ext_byte = {4'h0, pps_omf, pps_ptp, 1'b0};
                default: ext_byte = 8'h00;
            endcase
        end else if (header_type == HT_STATUS) begin
            case (ext_idx)
                5'd0:    ext_byte = status_internal_temp;
                5'd1:    ext_byte = {4'h0, status_present};
                5'd3:    ext_byte = {5'h00, status_event};
                5'd4:    ext_byte = {6'h00, status_temp};
                default: ext_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        case (byte_idx[1:0])
            2'd0:    pdo_byte = pdo_rd_data[7:0];
            2'd1:    pdo_byte = pdo_rd_data[15:8];
            2'd2:    pdo_byte = pdo_rd_data[23:16];
            default: pdo_byte = pdo_rd_data[31:24];
        endcase
    end

    always_comb begin
        payload_byte = 8'h00;
        case (message_type)
            MSG_TYPE_DATA: begin
                if (header_type == HT_SRC_CAP) begin
                    payload_byte = pdo_byte;
                end else if (header_type == HT_ALERT && byte_idx[1:0] == 2'd3) begin
                    payload_byte = {4'h0, alert_info};
                end
            end
            MSG_TYPE_EXTENDED: begin
                if (byte_idx == 5'd0) begin
                    payload_byte = ex_data_size[7:0];
                end else if (byte_idx == 5'd1) begin
                    payload_byte = {7'h00, ex_data_size[8]};
                end else if ({4'h0, ext_idx} < ex_data_size) begin
                    payload_byte = ext_byte;
                end
            end
            default: payload_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/prl_tx_message_build.sv
// USB-PD TX message builder: captures request fields on build_start, then streams
// header and data objects LSB-byte-first over a valid/ready byte handshake.
module prl_tx_message_build
    import prl_pkg::*;
#(
    parameter logic [1:0] SPEC_REV = 2'b10,
    parameter int         PDO_AW   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              build_start,
    input  logic              build_abort,
    input  logic [2:0]        msg_id,
    input  logic              port_power_role,
    input  logic              port_data_role,
    input  logic [2:0]        if_sop_type,
    input  logic [1:0]        if_message_type,
    input  logic [4:0]        if_header_type,
    input  logic [3:0]        if_source_cap_table_select,
    input  logic [2:0]        if_pdo_num,
    input  logic [3:0]        if_alert_message_info,
    input  logic [8:0]        if_ex_data_size,
    input  logic              if_ex_pps_omf,
    input  logic [1:0]        if_ex_pps_ptp,
    input  logic [7:0]        if_ex_pps_output_current,
    input  logic [15:0]       if_ex_pps_output_voltage,
    input  logic [1:0]        if_ex_status_temp_status,
    input  logic [2:0]        if_ex_status_event_flag,
    input  logic [3:0]        if_ex_status_present_input,
    input  logic [7:0]        if_ex_status_internal_temp,
    output logic [PDO_AW-1:0] pdo_rd_addr,
    input  logic [31:0]       pdo_rd_data,
    output logic [7:0]        tx_byte,
    output logic              tx_byte_valid,
    input  logic              tx_byte_ready,
    output logic              tx_byte_last,
    output logic [2:0]        tx_sop_type,
    output logic              build_busy,
    output logic              build_done
);

    build_state_t state_reg, state_next;
    logic [4:0]   cnt_reg, cnt_next;
    req_t         req_reg, req_in;

    logic         capture;
    logic         accept;
    logic [2:0]   ndo;
    logic [9:0]   ext_sum;
    logic [4:0]   last_idx;
    logic         is_sop;
    logic [15:0]  header;
    logic [7:0]   payload_byte;

    assign req_in = '{
        msg_id:               msg_id,
        power_role:           port_power_role,
        data_role:            port_data_role,
        sop_type:             if_sop_type,
        message_type:         if_message_type,
        header_type:          if_header_type,
        table_select:         if_source_cap_table_select,
        pdo_num:              if_pdo_num,
        alert_info:           if_alert_message_info,
        ex_data_size:         if_ex_data_size,
        pps_omf:              if_ex_pps_omf,
        pps_ptp:              if_ex_pps_ptp,
        pps_current:          if_ex_pps_output_current,
        pps_voltage:          if_ex_pps_output_voltage,
        status_temp:          if_ex_status_temp_status,
        status_event:         if_ex_status_event_flag,
        status_present:       if_ex_status_present_input,
        status_internal_temp: if_ex_status_internal_temp
    };

    assign capture = (state_reg == ST_IDLE) && build_start && !build_abort;
    assign accept  = tx_byte_valid && tx_byte_ready;

    // Extended: ceil((2 + size) / 4) == (size + 5) >> 2, saturated to the 3-bit field.
    assign ext_sum = {1'b0, req_reg.ex_data_size} + 10'd5;

    always_comb begin
        ndo = 3'd0;
        case (req_reg.message_type)
            MSG_TYPE_DATA: begin
                if (req_reg.header_type == HT_SRC_CAP) begin
                    ndo = req_reg.pdo_num;
                end else if (req_reg.header_type == HT_ALERT) begin
                    ndo = 3'd1;
                end
            end
            MSG_TYPE_EXTENDED: ndo = (ext_sum[9:2] > 8'd7) ? 3'd7 : ext_sum[4:2];
            default:           ndo = 3'd0;
        endcase
    end

    assign last_idx = {ndo, 2'b00} - 5'd1;
    assign is_sop   = (req_reg.sop_type == SOP_SOP);
    assign header   = {(req_reg.message_type == MSG_TYPE_EXTENDED), ndo, req_reg.msg_id,
                       is_sop & req_reg.power_role, SPEC_REV,
                       is_sop & req_reg.data_role, req_reg.header_type};

    assign pdo_rd_addr = PDO_AW'({req_reg.table_select, cnt_reg[4:2]});
    assign tx_sop_type = req_reg.sop_type;

    prl_tx_payload_mux u_payload_mux (
        .message_type         (req_reg.message_type),
        .header_type          (req_reg.header_type),
        .byte_idx             (cnt_reg),
        .pdo_rd_data          (pdo_rd_data),
        .alert_info           (req_reg.alert_info),
        .ex_data_size         (req_reg.ex_data_size),
        .pps_omf              (req_reg.pps_omf),
        .pps_ptp              (req_reg.pps_ptp),
        .pps_current          (req_reg.pps_current),
        .pps_voltage          (req_reg.pps_voltage),
        .status_temp          (req_reg.status_temp),
        .status_event         (req_reg.status_event),
        .status_present       (req_reg.status_present),
        .status_internal_temp (req_reg.status_internal_temp),
        .payload_byte         (payload_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 5'd0;
            req_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                req_reg <= req_in;
            end
        end
    end

    // cnt_reg indexes header bytes (0..1) in HDR and data bytes in DATA.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tx_byte       = 8'h00;
        tx_byte_valid = 1'b0;
        tx_byte_last  = 1'b0;
        build_busy    = (state_reg != ST_IDLE);
        build_done    = 1'b0;

        case (state_reg)
            ST_HDR: begin
                tx_byte_valid = 1'b1;
                tx_byte       = cnt_reg[0] ? header[15:8] : header[7:0];
                tx_byte_last  = cnt_reg[0] && (ndo == 3'd0);
                if (accept) begin
                    if (cnt_reg[0]) begin
                        cnt_next   = 5'd0;
                        state_next = (ndo == 3'd0) ? ST_DONE : ST_DATA;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                tx_byte_valid = 1'b1;
                tx_byte       = payload_byte;
                tx_byte_last  = (cnt_reg == last_idx);
                if (accept) begin
                    if (cnt_reg == last_idx) begin
                        cnt_next   = 5'd0;
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                build_done = !build_abort;
                state_next = ST_IDLE;
            end
            default: begin
                if (build_start) begin
                    cnt_next   = 5'd0;
                    state_next = ST_HDR;
                end
            end
        endcase

        if (build_abort) begin
            state_next = ST_IDLE;
            cnt_next   = 5'd0;
        end
    end

endmodule

// File: tb/tb_prl_tx_message_build.sv
// Directed bench for prl_tx_message_build: hand-computed byte streams per message,
// handshake hold checks under random ready, abort and reset behaviour.
module tb_prl_tx_message_build;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        build_start = 1'b0;
    logic        build_abort = 1'b0;
    logic [2:0]  msg_id = '0;
    logic        port_power_role = 1'b0;
    logic        port_data_role = 1'b0;
    logic [2:0]  if_sop_type = '0;
    logic [1:0]  if_message_type = '0;
    logic [4:0]  if_header_type = '0;
    logic [3:0]  if_source_cap_table_select = '0;
    logic [2:0]  if_pdo_num = '0;
    logic [3:0]  if_alert_message_info = '0;
    logic [8:0]  if_ex_data_size = '0;
    logic        if_ex_pps_omf = 1'b0;
    logic [1:0]  if_ex_pps_ptp = '0;
    logic [7:0]  if_ex_pps_output_current = '0;
    logic [15:0] if_ex_pps_output_voltage = '0;
    logic [1:0]  if_ex_status_temp_status = '0;
    logic [2:0]  if_ex_status_event_flag = '0;
    logic [3:0]  if_ex_status_present_input = '0;
    logic [7:0]  if_ex_status_internal_temp = '0;
    logic [6:0]  pdo_rd_addr;
    logic [31:0] pdo_rd_data;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready = 1'b0;
    logic        tx_byte_last;
    logic [2:0]  tx_sop_type;
    logic        build_busy;
    logic        build_done;

    logic [31:0] pdo_mem [0:127];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          failures = 0;

    assign pdo_rd_data = pdo_mem[pdo_rd_addr];

    always #5 clk = ~clk;

    prl_tx_message_build dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .build_start                (build_start),
        .build_abort                (build_abort),
        .msg_id                     (msg_id),
        .port_power_role            (port_power_role),
        .port_data_role             (port_data_role),
        .if_sop_type                (if_sop_type),
        .if_message_type            (if_message_type),
        .if_header_type             (if_header_type),
        .if_source_cap_table_select (if_source_cap_table_select),
        .if_pdo_num                 (if_pdo_num),
        .if_alert_message_info      (if_alert_message_info),
        .if_ex_data_size            (if_ex_data_size),
        .if_ex_pps_omf              (if_ex_pps_omf),
        .if_ex_pps_ptp              (if_ex_pps_ptp),
        .if_ex_pps_output_current   (if_ex_pps_output_current),
        .if_ex_pps_output_voltage   (if_ex_pps_output_voltage),
        .if_ex_status_temp_status   (if_ex_status_temp_status),
        .if_ex_status_event_flag    (if_ex_status_event_flag),
        .if_ex_status_present_input (if_ex_status_present_input),
        .if_ex_status_internal_temp (if_ex_status_internal_temp),
        .pdo_rd_addr                (pdo_rd_addr),
        .pdo_rd_data                (pdo_rd_data),
        .tx_byte                    (tx_byte),
        .tx_byte_valid              (tx_byte_valid),
        .tx_byte_ready              (tx_byte_ready),
        .tx_byte_last               (tx_byte_last),
        .tx_sop_type                (tx_sop_type),
        .build_busy                 (build_busy),
        .build_done                 (build_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] mt, input logic [4:0] ht, input logic [2:0] id,
                        input logic [2:0] sop, input logic pr, input logic dr);
        if_message_type = mt;
        if_header_type = ht;
        msg_id = id;
        if_sop_type = sop;
        port_power_role = pr;
        port_data_role = dr;
        if_source_cap_table_select = '0;
        if_pdo_num = '0;
        if_alert_message_info = '0;
        if_ex_data_size = '0;
        if_ex_pps_omf = 1'b0;
        if_ex_pps_ptp = '0;
        if_ex_pps_output_current = '0;
        if_ex_pps_output_voltage = '0;
        if_ex_status_temp_status = '0;
        if_ex_status_event_flag = '0;
        if_ex_status_present_input = '0;
        if_ex_status_internal_temp = '0;
    endtask

    // Start a build and drain it against exp_q; rnd randomises ready each cycle.
    task automatic send(input string name, input logic [2:0] exp_sop, input bit rnd);
        int         got;
        int         cyc;
        logic       hold_v;
        logic [7:0] hold_b;
        logic       hold_l;
        got = 0;
        cyc = 0;
        hold_v = 1'b0;
        hold_b = 8'h00;
        hold_l = 1'b0;
        @(negedge clk);
        build_start = 1'b1;
        @(negedge clk);
        build_start = 1'b0;
        check({name, "_latency_valid"}, {31'd0, tx_byte_valid}, 32'd1);
        while (got < exp_q.size() && cyc < 400) begin
            tx_byte_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            check({name, "_sop"}, {29'd0, tx_sop_type}, {29'd0, exp_sop});
            check({name, "_done_early"}, {31'd0, build_done}, 32'd0);
            if (hold_v) begin
                check({name, "_hold_byte"}, {24'd0, tx_byte}, {24'd0, hold_b});
                check({name, "_hold_last"}, {31'd0, tx_byte_last}, {31'd0, hold_l});
            end
            if (tx_byte_valid && tx_byte_ready) begin
                check($sformatf("%s_b%0d", name, got), {24'd0, tx_byte}, {24'd0, exp_q[got]});
                check($sformatf("%s_last%0d", name, got), {31'd0, tx_byte_last},
                      (got == exp_q.size() - 1) ? 32'd1 : 32'd0);
                got++;
                hold_v = 1'b0;
            end else if (tx_byte_valid) begin
                hold_v = 1'b1;
                hold_b = tx_byte;
                hold_l = tx_byte_last;
            end else begin
                check({name, "_valid_gap"}, {31'd0, tx_byte_valid}, 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        tx_byte_ready = 1'b0;
        if (got < exp_q.size()) check({name, "_timeout"}, got, exp_q.size());
        check({name, "_done_pulse"}, {31'd0, build_done}, 32'd1);
        check({name, "_valid_after"}, {31'd0, tx_byte_valid}, 32'd0);
        @(negedge clk);
        check({name, "_done_low"}, {31'd0, build_done}, 32'd0);
        check({name, "_busy_low"}, {31'd0, build_busy}, 32'd0);
        $display("msg %s: %0d bytes accepted in %0d cycles", name, got, cyc);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) pdo_mem[i] = 32'hDEAD_0000 | i;
        pdo_mem[7'h18] = 32'h0001_912C;
        pdo_mem[7'h19] = 32'h0002_D0C8;

        // Reset: inputs deliberately non-zero; outputs must still be 0.
        if_sop_type = 3'd2;
        if_header_type = 5'h1F;
        #12;
        check("rst_valid", {31'd0, tx_byte_valid}, 32'd0);
        check("rst_busy", {31'd0, build_busy}, 32'd0);
        check("rst_done", {31'd0, build_done}, 32'd0);
        check("rst_last", {31'd0, tx_byte_last}, 32'd0);
        check("rst_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_sop", {29'd0, tx_sop_type}, 32'd0);
        check("rst_addr", {25'd0, pdo_rd_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // GoodCRC: hdr 0x0B81
        load(2'd0, 5'h01, 3'd5, 3'd0, 1'b1, 1'b0);
        exp_q = '{8'h81, 8'h0B};
        send("goodcrc", 3'd0, 1'b0);

        // Source_Capabilities, 2 PDOs from table 3: hdr 0x21A1
        load(2'd1, 5'h01, 3'd0, 3'd0, 1'b1, 1'b1);
        if_source_cap_table_select = 4'd3;
        if_pdo_num = 3'd2;
        exp_q = '{8'hA1, 8'h21, 8'h2C, 8'h91, 8'h01, 8'h00, 8'hC8, 8'hD0, 8'h02, 8'h00};
        send("srccap", 3'd0, 1'b0);

        // PPS_Status: hdr 0xA6AC, ext hdr 0x0004
        load(2'd2, 5'h0C, 3'd3, 3'd0, 1'b0, 1'b1);
        if_ex_data_size = 9'd4;
        if_ex_pps_output_voltage = 16'h1234;
        if_ex_pps_output_current = 8'h64;
        if_ex_pps_omf = 1'b1;
        if_ex_pps_ptp = 2'd2;
        exp_q = '{8'hAC, 8'hA6, 8'h04, 8'h00, 8'h34, 8'h12, 8'h64, 8'h0C, 8'h00, 8'h00};
        send("pps_status", 3'd0, 1'b0);

        // Alert on SOP': roles masked, hdr 0x1E86
        load(2'd1, 5'h06, 3'd7, 3'd1, 1'b1, 1'b1);
        if_alert_message_info = 4'b0010;
        exp_q = '{8'h86, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h02};
        send("alert", 3'd1, 1'b0);

        // Status on SOP'': hdr 0xA282
        load(2'd2, 5'h02, 3'd1, 3'd2, 1'b1, 1'b1);
        if_ex_data_size = 9'd6;
        if_ex_status_internal_temp = 8'h2A;
        if_ex_status_present_input = 4'h5;
        if_ex_status_event_flag = 3'd3;
        if_ex_status_temp_status = 2'd2;
        exp_q = '{8'h82, 8'hA2, 8'h06, 8'h00, 8'h2A, 8'h05, 8'h00, 8'h03, 8'h02, 8'h00};
        send("status", 3'd2, 1'b0);

        // Reserved message type is header-only: hdr 0x0485
        load(2'd3, 5'h05, 3'd2, 3'd0, 1'b0, 1'b0);
        exp_q = '{8'h85, 8'h04};
        send("reserved", 3'd0, 1'b0);

        // Extended size 40 saturates NDO at 7: hdr 0xF08C, 28 data bytes
        load(2'd2, 5'h0C, 3'd0, 3'd0, 1'b0, 1'b0);
        if_ex_data_size = 9'd40;
        if_ex_pps_output_voltage = 16'h1234;
        if_ex_pps_output_current = 8'h64;
        if_ex_pps_omf = 1'b1;
        if_ex_pps_ptp = 2'd2;
        exp_q = '{8'h8C, 8'hF0, 8'h28, 8'h00, 8'h34, 8'h12, 8'h64, 8'h0C};
        for (int i = 0; i < 22; i++) exp_q.push_back(8'h00);
        send("ext_sat", 3'd0, 1'b0);

        // SrcCap with random ready: hdr 0x23A1
        load(2'd1, 5'h01, 3'd1, 3'd0, 1'b1, 1'b1);
        if_source_cap_table_select = 4'd3;
        if_pdo_num = 3'd2;
        exp_q = '{8'hA1, 8'h23, 8'h2C, 8'h91, 8'h01, 8'h00, 8'hC8, 8'hD0, 8'h02, 8'h00};
        send("srccap_rnd", 3'd0, 1'b1);
        send("srccap_rnd2", 3'd0, 1'b1);

        // Abort mid-DATA together with a start strobe.
        @(negedge clk);
        build_start = 1'b1;
        @(negedge clk);
        build_start = 1'b0;
        tx_byte_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", {31'd0, build_busy}, 32'd1);
        build_abort = 1'b1;
        build_start = 1'b1;
        @(negedge clk);
        build_abort = 1'b0;
        build_start = 1'b0;
        tx_byte_ready = 1'b0;
        check("abort_busy", {31'd0, build_busy}, 32'd0);
        check("abort_valid", {31'd0, tx_byte_valid}, 32'd0);
        check("abort_last", {31'd0, tx_byte_last}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_no_done%0d", i), {31'd0, build_done}, 32'd0);
            @(negedge clk);
        end
        $display("msg abort: builder returned to idle");

        // Abort wins over a start issued in IDLE.
        build_abort = 1'b1;
        build_start = 1'b1;
        @(negedge clk);
        build_abort = 1'b0;
        build_start = 1'b0;
        check("abort_start_idle", {31'd0, build_busy}, 32'd0);

        send("after_abort", 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
